// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// One operation in flight: IDLE accepts, EXEC drives the ALU and captures, RESP holds the result.
package cpu_types_pkg;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [OP_W-1:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        word_t           a;
        word_t           b;
    } alu_req_t;

    typedef struct packed {
        word_t             result;
        logic [FLAG_W-1:0] flags;
    } alu_resp_t;
endpackage

module alu_arbiter
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [WORD_W-1:0] req0_a,
    input  logic [WORD_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [WORD_W-1:0] req1_a,
    input  logic [WORD_W-1:0] req1_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [WORD_W-1:0] resp0_result,
    output logic [FLAG_W-1:0] resp0_flags,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [WORD_W-1:0] resp1_result,
    output logic [FLAG_W-1:0] resp1_flags,
    output logic [WORD_W-1:0] alu_port_a,
    output logic [WORD_W-1:0] alu_port_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [WORD_W-1:0] alu_result,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t    state_q, state_d;
    logic      owner_q, owner_d;
    logic      last_grant_q, last_grant_d;
    logic      busy_q, busy_d;
    alu_req_t  opnd_q, opnd_d;
    logic [1:0] rvalid_q, rvalid_d;
    alu_resp_t rdata_q [2];
    alu_resp_t rdata_d [2];

    logic grant_vld;
    logic grant;
    logic owner_resp_ready;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    end

    assign req0_ready       = (state_q == IDLE) && grant_vld && !grant;
    assign req1_ready       = (state_q == IDLE) && grant_vld && grant;
    assign owner_resp_ready = owner_q ? resp1_ready : resp0_ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        opnd_d       = opnd_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    opnd_d       = grant ? '{op: req1_op, a: req1_a, b: req1_b}
                                         : '{op: req0_op, a: req0_a, b: req0_b};
                    owner_d      = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // ALU is combinational, so its output reflects opnd_q this cycle.
                rdata_d[owner_q]  = '{result: alu_result,
                                      flags:  {alu_overflow, alu_negative, alu_zero}};
                rvalid_d[owner_q] = 1'b1;
                state_d           = RESP;
            end
            RESP: begin
                if (owner_resp_ready) begin
                    rvalid_d[owner_q] = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            opnd_q       <= '{op: OP_W'(ALU_SLL), a: '0, b: '0};
            rvalid_q     <= '0;
            rdata_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            opnd_q       <= opnd_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign alu_port_a   = opnd_q.a;
    assign alu_port_b   = opnd_q.b;
    assign alu_op       = opnd_q.op;
    assign resp0_valid  = rvalid_q[0];
    assign resp1_valid  = rvalid_q[1];
    assign resp0_result = rdata_q[0].result;
    assign resp0_flags  = rdata_q[0].flags;
    assign resp1_result = rdata_q[1].result;
    assign resp1_flags  = rdata_q[1].flags;
    assign busy         = busy_q;
    assign last_grant   = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a transaction-level round-robin model.
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  v;
    logic [3:0]  op [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [1:0]  rr;
    wire  [1:0]  rdy;
    wire  [1:0]  rv;
    wire  [31:0] rres0, rres1;
    wire  [2:0]  rflg0, rflg1;
    wire  [31:0] alu_port_a, alu_port_b;
    wire  [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_negative, alu_overflow, alu_zero;
    wire         busy, last_grant;

    int tests = 0;
    int fails = 0;
    int mdl_last = 1;

    always #5 CLK = ~CLK;

    alu_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_op(op[0]), .req0_a(a[0]), .req0_b(b[0]),
        .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_op(op[1]), .req1_a(a[1]), .req1_b(b[1]),
        .resp0_valid(rv[0]), .resp0_ready(rr[0]), .resp0_result(rres0), .resp0_flags(rflg0),
        .resp1_valid(rv[1]), .resp1_ready(rr[1]), .resp1_result(rres1), .resp1_flags(rflg1),
        .alu_port_a(alu_port_a), .alu_port_b(alu_port_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .busy(busy), .last_grant(last_grant)
    );

    // Returns {result[31:0], overflow, negative, zero}.
    function automatic logic [34:0] alu_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        ov;
        ov = 1'b0;
        case (o)
            4'd0: r = x << y[4:0];
            4'd1: r = x >> y[4:0];
            4'd2: begin r = x + y; ov = (x[31] == y[31]) && (r[31] != x[31]); end
            4'd3: begin r = x - y; ov = (x[31] != y[31]) && (r[31] != x[31]); end
            4'd4: r = x & y;
            4'd5: r = x | y;
            4'd6: r = x ^ y;
            4'd7: r = ~(x | y);
            4'd8: r = {31'b0, $signed(x) < $signed(y)};
            4'd9: r = {31'b0, x < y};
            default: r = '0;
        endcase
        return {r, ov, r[31], r == 32'd0};
    endfunction

    always_comb {alu_result, alu_overflow, alu_negative, alu_zero} = alu_ref(alu_op, alu_port_a, alu_port_b);

    function automatic logic [31:0] res_of(input int n);
        return (n == 1) ? rres1 : rres0;
    endfunction

    function automatic logic [2:0] flg_of(input int n);
        return (n == 1) ? rflg1 : rflg0;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic new_req(input int n);
        v[n]  = 1'b1;
        op[n] = 4'($urandom_range(0, 9));
        a[n]  = $urandom;
        b[n]  = ($urandom_range(0, 3) == 0) ? a[n] : $urandom;
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        v = '0; rr = '0;
        for (int i = 0; i < 2; i++) begin op[i] = '0; a[i] = '0; b[i] = '0; end
        tick(); tick();
        nRST = 1'b1;
        mdl_last = 1;
        #1;
    endtask

    // Serve one transaction for requester w, whose request is already presented.
    task automatic serve(input int w, input int delay, input bit keep);
        logic [34:0] exp;
        logic [1:0]  wmask;
        wmask = 2'(1 << w);
        exp = alu_ref(op[w], a[w], b[w]);
        tests++;
        if (rdy !== wmask) begin fails++; $display("FAIL grant: ready=%b expected %b", rdy, wmask); end
        rr = 2'($urandom_range(0, 3));
        rr[w] = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b1 || alu_port_a !== a[w] || alu_port_b !== b[w] || alu_op !== op[w]) begin
            fails++;
            $display("FAIL exec_drive: busy=%b a=%h b=%h op=%h expected 1 %h %h %h",
                     busy, alu_port_a, alu_port_b, alu_op, a[w], b[w], op[w]);
        end
        tests++;
        if (last_grant !== 1'(w) || rdy !== 2'b00 || rv !== 2'b00) begin
            fails++;
            $display("FAIL exec_ctrl: last_grant=%b ready=%b rvalid=%b expected %0d 00 00", last_grant, rdy, rv, w);
        end
        if (keep) new_req(w); else v[w] = 1'b0;
        tick();
        for (int d = 0; d <= delay; d++) begin
            tests++;
            if (rv !== wmask || res_of(w) !== exp[34:3] || flg_of(w) !== exp[2:0] || rdy !== 2'b00) begin
                fails++;
                $display("FAIL resp_hold: rvalid=%b result=%h flags=%b ready=%b expected %b %h %b 00",
                         rv, res_of(w), flg_of(w), rdy, wmask, exp[34:3], exp[2:0]);
            end
            if (d == delay) rr[w] = 1'b1;
            tick();
        end
        rr = '0;
        #1;
        tests++;
        if (rv !== 2'b00 || busy !== 1'b0 || res_of(w) !== exp[34:3] || flg_of(w) !== exp[2:0]) begin
            fails++;
            $display("FAIL resp_done: rvalid=%b busy=%b result=%h flags=%b expected 00 0 %h %b",
                     rv, busy, res_of(w), flg_of(w), exp[34:3], exp[2:0]);
        end
        mdl_last = w;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (busy !== 1'b0 || last_grant !== 1'b1 || rv !== 2'b00 || rdy !== 2'b00) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%b last_grant=%b rvalid=%b ready=%b expected 0 1 00 00", busy, last_grant, rv, rdy);
        end
        tests++;
        if (rres0 !== 0 || rres1 !== 0 || rflg0 !== 0 || rflg1 !== 0 ||
            alu_port_a !== 0 || alu_port_b !== 0 || alu_op !== 0) begin
            fails++;
            $display("FAIL reset_data: r0=%h r1=%h f0=%b f1=%b a=%h b=%h op=%h expected all zero",
                     rres0, rres1, rflg0, rflg1, alu_port_a, alu_port_b, alu_op);
        end
        v[1] = 1'b1; #1;
        tests++;
        if (rdy !== 2'b10) begin fails++; $display("FAIL reset_ready: ready=%b expected 10", rdy); end
        v[1] = 1'b0; #1;
    endtask

    task automatic test_single();
        v[0] = 1'b1; op[0] = 4'd2; a[0] = 32'd5; b[0] = 32'd7; #1;
        serve(0, 0, 1'b0);
        tests++;
        if (rres0 !== 32'd12 || rflg0 !== 3'b000) begin
            fails++; $display("FAIL single_add: result=%h flags=%b expected 0000000c 000", rres0, rflg0);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        v = 2'b11;
        op[0] = 4'd3; a[0] = 32'd3; b[0] = 32'd3;
        op[1] = 4'd5; a[1] = 32'hF0; b[1] = 32'h0F;
        #1;
        serve(0, 0, 1'b0);
        tests++;
        if (rres0 !== 32'd0 || rflg0 !== 3'b001) begin
            fails++; $display("FAIL tie_req0: result=%h flags=%b expected 00000000 001", rres0, rflg0);
        end
        serve(1, 0, 1'b0);
        tests++;
        if (rres1 !== 32'hFF || last_grant !== 1'b1) begin
            fails++; $display("FAIL tie_req1: result=%h last_grant=%b expected 000000ff 1", rres1, last_grant);
        end
    endtask

    task automatic test_flags();
        v[1] = 1'b1; op[1] = 4'd3; a[1] = 32'h8000_0000; b[1] = 32'd1; #1;
        serve(1, 0, 1'b0);
        tests++;
        if (rres1 !== 32'h7FFF_FFFF || rflg1 !== 3'b100) begin
            fails++; $display("FAIL flags_ovf: result=%h flags=%b expected 7fffffff 100", rres1, rflg1);
        end
    endtask

    task automatic test_fairness();
        new_req(0); new_req(1); #1;
        for (int i = 0; i < 4; i++) serve(1 - mdl_last, 0, 1'b1);
        v = '0; #1;
    endtask

    task automatic test_back_to_back();
        new_req(0); new_req(1); #1;
        serve(1 - mdl_last, 5, 1'b0);
        serve(1 - mdl_last, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        new_req(0); #1;
        tick();
        nRST = 1'b0; #1;
        mdl_last = 1;
        tests++;
        if (busy !== 1'b0 || rv !== 2'b00 || alu_port_a !== 0 || last_grant !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: busy=%b rvalid=%b a=%h last_grant=%b expected 0 00 0 1", busy, rv, alu_port_a, last_grant);
        end
        v = '0; rr = 2'b11;
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (rv !== 2'b00 || busy !== 1'b0) begin
                fails++; $display("FAIL reset_no_resp: rvalid=%b busy=%b expected 00 0", rv, busy);
            end
        end
        rr = '0; #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            for (int n = 0; n < 2; n++) if (!v[n] && $urandom_range(0, 2) != 0) new_req(n);
            if (v == 2'b00) begin
                #1;
                tests++;
                if (rdy !== 2'b00 || busy !== 1'b0) begin
                    fails++; $display("FAIL idle_none: ready=%b busy=%b expected 00 0", rdy, busy);
                end
                tick();
                continue;
            end
            #1;
            serve((v == 2'b11) ? 1 - mdl_last : (v[1] ? 1 : 0),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        v = '0; #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_flags();
        test_fairness();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
